// File: rtl/tv80_dma_ctl_if.sv
// tv80_dma_ctl_if: bundles the job-control, core bus-handshake and memory
// bus signals of the TV80 block-copy DMA controller.
//   slave  : the DMA controller (accepts jobs, answers with bus cycles)
//   master : the environment (host that starts jobs, CPU core, memory)
interface tv80_dma_ctl_if;
  logic        start;
  logic [15:0] src;
  logic [15:0] dst;
  logic [15:0] len;
  logic        abort;
  logic        busrq_n;
  logic        busak_n;
  logic        wait_n;
  logic [7:0]  di;
  logic [15:0] dma_a;
  logic [7:0]  dma_dout;
  logic        dma_mreq_n;
  logic        dma_rd_n;
  logic        dma_wr_n;
  logic        dma_oe;
  logic        busy;
  logic        done;
  logic [15:0] remaining;

  modport slave (
    input  start, src, dst, len, abort, busak_n, wait_n, di,
    output busrq_n, dma_a, dma_dout, dma_mreq_n, dma_rd_n, dma_wr_n,
           dma_oe, busy, done, remaining
  );

  modport master (
    output start, src, dst, len, abort, busak_n, wait_n, di,
    input  busrq_n, dma_a, dma_dout, dma_mreq_n, dma_rd_n, dma_wr_n,
           dma_oe, busy, done, remaining
  );
endinterface

// File: rtl/tv80_dma_ctl.sv
// tv80_dma_ctl: memory-to-memory block-copy DMA for the TV80 system bus.
// Requests the bus via busrq_n/busak_n, runs Z80-style read then write
// cycles per byte, and releases the bus after every BURST_LEN transfers
// (then waits HOLDOFF clocks before asking again) so the CPU keeps running.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : job control (start/src/dst/len/abort), status (busy/done/
//           remaining), core handshake (busrq_n/busak_n) and memory bus
//           (dma_a/dma_dout/di/strobes/wait_n/dma_oe)
//
// state | meaning
// IDLE  | no job; waits for start
// REQ   | busrq_n low, waiting for busak_n
// RD1   | read address out, mreq/rd strobes low
// RD2   | read strobes held, stretched by wait_n
// RD3   | strobes high, read data captured
// WR1   | write address/data out, mreq low
// WR2   | wr strobe low, stretched by wait_n
// WR3   | strobes high, pointers/counters advance
// REL   | bus handed back, waiting for busak_n high
// HOLD  | holdoff between bursts before re-request
module tv80_dma_ctl #(
  parameter int unsigned BURST_LEN = 16,
  parameter int unsigned HOLDOFF   = 4
) (
  input  logic          clk,
  input  logic          reset,
  tv80_dma_ctl_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, REQ, RD1, RD2, RD3, WR1, WR2, WR3, REL, HOLD
  } state_t;

  localparam logic [15:0] BURST_MAX = 16'(BURST_LEN);
  localparam logic [15:0] HOLD_CYC  = 16'(HOLDOFF);

  state_t      state_q, state_d;
  logic [15:0] src_q, src_d;
  logic [15:0] dst_q, dst_d;
  logic [15:0] rem_q, rem_d;
  logic [15:0] burst_q, burst_d;
  logic [15:0] hold_q, hold_d;
  logic [7:0]  data_q, data_d;
  logic        final_q, final_d;
  logic        done_q, done_d;
  logic [15:0] rem_dec;
  logic [15:0] burst_inc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      burst_q <= '0;
      hold_q  <= '0;
      data_q  <= '0;
      final_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      burst_q <= burst_d;
      hold_q  <= hold_d;
      data_q  <= data_d;
      final_q <= final_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    rem_d     = rem_q;
    burst_d   = burst_q;
    hold_d    = hold_q;
    data_d    = data_q;
    final_d   = final_q;
    done_d    = 1'b0;
    rem_dec   = rem_q - 16'd1;
    burst_inc = burst_q + 16'd1;
    case (state_q)
      IDLE: begin
        // a zero-length job completes at once without touching the bus
        if (bus.start) begin
          if (bus.len != 16'd0) begin
            src_d   = bus.src;
            dst_d   = bus.dst;
            rem_d   = bus.len;
            state_d = REQ;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      REQ: begin
        if (!bus.busak_n) begin
          burst_d = '0;
          state_d = RD1;
        end
      end
      RD1: state_d = RD2;
      RD2: if (bus.wait_n) state_d = RD3;
      RD3: begin
        data_d  = bus.di;
        state_d = WR1;
      end
      WR1: state_d = WR2;
      WR2: if (bus.wait_n) state_d = WR3;
      WR3: begin
        // 16-bit pointers wrap modulo 2^16 by construction
        src_d   = src_q + 16'd1;
        dst_d   = dst_q + 16'd1;
        rem_d   = rem_dec;
        burst_d = burst_inc;
        if (rem_dec == 16'd0 || bus.abort) begin
          final_d = 1'b1;
          state_d = REL;
        end else if (BURST_LEN != 0 && burst_inc == BURST_MAX) begin
          final_d = 1'b0;
          state_d = REL;
        end else begin
          state_d = RD1;
        end
      end
      REL: begin
        if (bus.busak_n) begin
          if (final_q) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            hold_d  = HOLD_CYC;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        // HOLD occupies HOLD_CYC cycles (at least one when HOLDOFF is 0)
        if (bus.abort) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (hold_q <= 16'd1) begin
          state_d = REQ;
        end else begin
          hold_d = hold_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs are decoded straight from the state register so that an
  // asynchronous reset releases strobes and busrq_n immediately.
  logic        busrq_n, oe, mreq_n, rd_n, wr_n;
  logic [15:0] addr;
  logic [7:0]  dout;

  always_comb begin
    busrq_n = 1'b1;
    oe      = 1'b0;
    mreq_n  = 1'b1;
    rd_n    = 1'b1;
    wr_n    = 1'b1;
    addr    = '0;
    dout    = '0;
    case (state_q)
      REQ: busrq_n = 1'b0;
      RD1, RD2: begin
        busrq_n = 1'b0;
        oe      = 1'b1;
        mreq_n  = 1'b0;
        rd_n    = 1'b0;
        addr    = src_q;
      end
      RD3: begin
        busrq_n = 1'b0;
        oe      = 1'b1;
        addr    = src_q;
      end
      WR1, WR2, WR3: begin
        busrq_n = 1'b0;
        oe      = 1'b1;
        mreq_n  = (state_q == WR3);
        wr_n    = (state_q != WR2);
        addr    = dst_q;
        dout    = data_q;
      end
      default: ;
    endcase
  end

  assign bus.busrq_n    = busrq_n;
  assign bus.dma_oe     = oe;
  assign bus.dma_mreq_n = mreq_n;
  assign bus.dma_rd_n   = rd_n;
  assign bus.dma_wr_n   = wr_n;
  assign bus.dma_a      = addr;
  assign bus.dma_dout   = dout;
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = done_q;
  assign bus.remaining  = rem_q;

endmodule

// File: tb/tb_tv80_dma_ctl.sv
// tb_tv80_dma_ctl: directed bench for tv80_dma_ctl with a memory/core
// model and a scoreboard of expected read addresses and write beats.
module tb_tv80_dma_ctl;
  logic clk = 1'b0;
  logic reset = 1'b1;

  tv80_dma_ctl_if bif();

  tv80_dma_ctl #(.BURST_LEN(16), .HOLDOFF(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bif.slave)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:65535];
  // during wait states the data bus carries inverted bytes, so an early
  // capture shows up as a data error
  assign bif.di = bif.wait_n ? mem[bif.dma_a] : ~mem[bif.dma_a];

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] exp_rd_q [$];
  logic [23:0] exp_wr_q [$];
  int rd_fall_cyc [$];
  int rel_writes [$];

  int cyc = 0, wr_total = 0, rd_total = 0, done_cnt = 0, extra = 0;
  int last_rd_low = 0, last_wr_low = 0, last_hold = 0, hold_run = 0;
  int rd_run = 0, wr_run = 0, rq_run = 0, viol = 0, rq_falls = 0;
  int rd_waits = 0, wr_waits = 0;
  logic rd_prev = 1'b1, wr_prev = 1'b1, rq_prev = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // monitor + core/memory model, evaluated once per negedge
  initial begin
    bif.busak_n = 1'b1;
    bif.wait_n  = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      if ((!bif.dma_mreq_n || !bif.dma_rd_n || !bif.dma_wr_n) && !bif.dma_oe) viol++;
      if (!bif.dma_rd_n) begin
        rd_run++;
        if (rd_prev) begin
          rd_total++;
          rd_fall_cyc.push_back(cyc);
          if (exp_rd_q.size() > 0) chk("rd_addr", 32'(bif.dma_a), 32'(exp_rd_q.pop_front()));
          else extra++;
        end
      end else begin
        if (!rd_prev) last_rd_low = rd_run;
        rd_run = 0;
      end
      if (!bif.dma_wr_n) begin
        wr_run++;
        if (wr_prev) begin
          logic [23:0] e;
          wr_total++;
          if (exp_wr_q.size() > 0) begin
            e = exp_wr_q.pop_front();
            chk("wr_addr", 32'(bif.dma_a), 32'(e[23:8]));
            chk("wr_data", 32'(bif.dma_dout), 32'(e[7:0]));
          end else extra++;
          mem[bif.dma_a] = bif.dma_dout;
        end
      end else begin
        if (!wr_prev) last_wr_low = wr_run;
        wr_run = 0;
      end
      if (bif.done) done_cnt++;
      if (!bif.busrq_n && rq_prev) begin
        rq_falls++;
        if (hold_run > 0) last_hold = hold_run;
      end
      if (bif.busrq_n && !rq_prev) rel_writes.push_back(wr_total);
      if (!bif.busrq_n) hold_run = 0;
      else if (bif.busak_n && bif.busy) hold_run++;
      rd_prev = bif.dma_rd_n;
      wr_prev = bif.dma_wr_n;
      rq_prev = bif.busrq_n;
      // core grants two cycles after the request, releases at once
      if (!bif.busrq_n) begin
        rq_run++;
        bif.busak_n = (rq_run >= 2) ? 1'b0 : 1'b1;
      end else begin
        rq_run = 0;
        bif.busak_n = 1'b1;
      end
      bif.wait_n = !((!bif.dma_rd_n && rd_run >= 2 && rd_run <= 1 + rd_waits) ||
                     (!bif.dma_wr_n && wr_run >= 1 && wr_run <= wr_waits));
    end
  end

  task automatic start_job(input logic [15:0] s, input logic [15:0] d,
                           input logic [15:0] l, input int npush);
    for (int i = 0; i < npush; i++) begin
      logic [15:0] sa, da;
      sa = s + 16'(i);
      da = d + 16'(i);
      exp_rd_q.push_back(sa);
      exp_wr_q.push_back({da, mem[sa]});
    end
    @(negedge clk);
    bif.src = s; bif.dst = d; bif.len = l; bif.start = 1'b1;
    @(negedge clk);
    bif.start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bif.done) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic finish_job(input string tag, input int exp_w, input int wbase,
                            input int dbase, input logic [15:0] exp_rem);
    bit seen;
    wait_done(400, seen);
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    repeat (3) @(negedge clk);
    chk({tag, "_done_pulses"}, 32'(done_cnt - dbase), 32'd1);
    chk({tag, "_writes"}, 32'(wr_total - wbase), 32'(exp_w));
    chk({tag, "_remaining"}, 32'(bif.remaining), 32'(exp_rem));
    chk({tag, "_busrq_n"}, 32'(bif.busrq_n), 32'd1);
    chk({tag, "_busy"}, 32'(bif.busy), 32'd0);
    chk({tag, "_sb_left"}, 32'(exp_wr_q.size() + exp_rd_q.size()), 32'd0);
    chk({tag, "_extra"}, 32'(extra), 32'd0);
  endtask

  initial begin
    #5000000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    int wb, db, rf, falls;
    logic p;
    bit ok;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    bif.start = 1'b0; bif.src = '0; bif.dst = '0; bif.len = '0; bif.abort = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busrq_n", 32'(bif.busrq_n), 32'd1);
    chk("rst_mreq_n", 32'(bif.dma_mreq_n), 32'd1);
    chk("rst_rd_n", 32'(bif.dma_rd_n), 32'd1);
    chk("rst_wr_n", 32'(bif.dma_wr_n), 32'd1);
    chk("rst_oe", 32'(bif.dma_oe), 32'd0);
    chk("rst_busy", 32'(bif.busy), 32'd0);
    chk("rst_done", 32'(bif.done), 32'd0);
    chk("rst_remaining", 32'(bif.remaining), 32'd0);
    chk("rst_dma_a", 32'(bif.dma_a), 32'd0);
    chk("rst_dout", 32'(bif.dma_dout), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // basic 3-byte copy, 6 clocks per transfer
    wb = wr_total; db = done_cnt;
    rd_fall_cyc.delete();
    start_job(16'h1000, 16'h2000, 16'd3, 3);
    finish_job("t1", 3, wb, db, 16'd0);
    chk("t1_xfer_clks", 32'((rd_fall_cyc.size() >= 2) ? rd_fall_cyc[1] - rd_fall_cyc[0] : -1), 32'd6);
    for (int i = 0; i < 3; i++)
      chk("t1_mem", 32'(mem[16'h2000 + i]), 32'(mem[16'h1000 + i]));

    // 20 bytes: one interim release after 16, 4-cycle holdoff
    wb = wr_total; db = done_cnt; rf = rq_falls;
    rel_writes.delete();
    start_job(16'h3000, 16'h4000, 16'd20, 20);
    finish_job("t2", 20, wb, db, 16'd0);
    chk("t2_releases", 32'(rel_writes.size()), 32'd2);
    chk("t2_first_burst", 32'((rel_writes.size() > 0) ? rel_writes[0] - wb : -1), 32'd16);
    chk("t2_holdoff", 32'(last_hold), 32'd4);
    chk("t2_requests", 32'(rq_falls - rf), 32'd2);

    // wait states: 3 in RD2, 2 in WR2
    rd_waits = 3; wr_waits = 2;
    wb = wr_total; db = done_cnt;
    start_job(16'h5000, 16'h6000, 16'd1, 1);
    finish_job("t3", 1, wb, db, 16'd0);
    chk("t3_rd_low", 32'(last_rd_low), 32'd5);
    chk("t3_wr_low", 32'(last_wr_low), 32'd3);
    rd_waits = 0; wr_waits = 0;

    // address wrap at 0xFFFF
    wb = wr_total; db = done_cnt;
    start_job(16'hFFFE, 16'h7FFF, 16'd4, 4);
    finish_job("t4", 4, wb, db, 16'd0);

    // zero-length job
    rf = rq_falls;
    @(negedge clk);
    bif.len = 16'd0; bif.start = 1'b1;
    @(negedge clk);
    bif.start = 1'b0;
    chk("t5_len0_done", 32'(bif.done), 32'd1);
    chk("t5_len0_busy", 32'(bif.busy), 32'd0);
    @(negedge clk);
    chk("t5_len0_done_drop", 32'(bif.done), 32'd0);
    chk("t5_len0_no_req", 32'(rq_falls - rf), 32'd0);

    // start while busy is ignored
    wb = wr_total; db = done_cnt;
    start_job(16'h0100, 16'h0200, 16'd2, 2);
    repeat (3) @(negedge clk);
    bif.src = 16'h0A00; bif.dst = 16'h0B00; bif.len = 16'd7; bif.start = 1'b1;
    @(negedge clk);
    bif.start = 1'b0;
    finish_job("t5_busy", 2, wb, db, 16'd0);

    // abort during RD2 of transfer 2 of 10
    wb = wr_total; db = done_cnt;
    start_job(16'h0300, 16'h0400, 16'd10, 2);
    falls = 0; p = 1'b1;
    for (int i = 0; i < 200 && falls < 2; i++) begin
      @(negedge clk);
      if (!bif.dma_rd_n && p) falls++;
      p = bif.dma_rd_n;
    end
    chk("t6_sync", 32'(falls), 32'd2);
    @(negedge clk);
    bif.abort = 1'b1;
    finish_job("t6", 2, wb, db, 16'd8);
    bif.abort = 1'b0;

    // asynchronous reset in WR2 discards the job
    start_job(16'h0500, 16'h0600, 16'd3, 1);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!bif.dma_wr_n) begin
        ok = 1'b1;
        break;
      end
    end
    chk("t7_sync", 32'(ok), 32'd1);
    db = done_cnt;
    #2 reset = 1'b1;
    #1;
    chk("t7_wr_n", 32'(bif.dma_wr_n), 32'd1);
    chk("t7_mreq_n", 32'(bif.dma_mreq_n), 32'd1);
    chk("t7_oe", 32'(bif.dma_oe), 32'd0);
    chk("t7_busrq_n", 32'(bif.busrq_n), 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("t7_no_done", 32'(done_cnt - db), 32'd0);
    chk("t7_busy", 32'(bif.busy), 32'd0);
    chk("t7_remaining", 32'(bif.remaining), 32'd0);
    chk("t7_sb_left", 32'(exp_wr_q.size() + exp_rd_q.size()), 32'd0);

    chk("strobe_without_oe", 32'(viol), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
